// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_REG  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  localparam int unsigned FIFO_DSIZE_DFLT     = 32;
  localparam int unsigned FIFO_ASIZE_DFLT     = 8;
  localparam int unsigned FIFO_AEMPTY_TH_DFLT = 4;
  // Default almost-full threshold sits this many words below DEPTH.
  localparam int unsigned FIFO_AFULL_MARGIN   = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// Simple dual-port RAM: synchronous write, combinational read.
module sfifo_mem #(
  parameter int unsigned DSIZE = 32,
  parameter int unsigned ASIZE = 8
) (
  input  logic             wclk,
  input  logic             wclken,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

`ifdef SFIFO_VENDOR_RAM
  vendor_dpram #(
    .DATA_WIDTH (DSIZE),
    .ADDR_WIDTH (ASIZE)
  ) u_vendor_ram (
    .wclk   (wclk),
    .wen    (wclken),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr  (raddr),
    .rdata  (rdata)
  );
`else
  localparam int unsigned Depth = 1 << ASIZE;

  logic [DSIZE-1:0] mem [Depth];

  always_ff @(posedge wclk) begin
    if (wclken) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, registered occupancy count, status flags,
// sticky error flags and optional registered read port around sfifo_mem.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = FIFO_DSIZE_DFLT,
  parameter int unsigned ASIZE     = FIFO_ASIZE_DFLT,
  parameter int unsigned AFULL_TH  = (2 ** ASIZE) - FIFO_AFULL_MARGIN,
  parameter int unsigned AEMPTY_TH = FIFO_AEMPTY_TH_DFLT,
  parameter int unsigned FWFT      = FIFO_MODE_FWFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int unsigned DEPTH = 2 ** ASIZE;

  if (!(AEMPTY_TH > 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_params
    $error("sync_fifo_ctrl: require 0 < AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  localparam logic [ASIZE:0] CntFull   = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] CntAFull  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] CntAEmpty = (ASIZE+1)'(AEMPTY_TH);
  localparam logic [ASIZE:0] PtrOne    = (ASIZE+1)'(1);

  logic [ASIZE:0]   wbin_q, rbin_q, count_q;
  logic             overflow_q, underflow_q;
  logic             overflow_d, underflow_d;
  logic             wacc, racc;
  logic [DSIZE-1:0] mem_rdata;

  // Pointer MSBs only matter for wrap; occupancy comes from count_q.
  logic unused_ptr_msb;
  assign unused_ptr_msb = wbin_q[ASIZE] ^ rbin_q[ASIZE];

  assign wfull         = (count_q == CntFull);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= CntAFull);
  assign ralmost_empty = (count_q <= CntAEmpty);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  assign wacc = winc & ~wfull & ~flush;
  assign racc = rinc & ~rempty & ~flush;

  // A new error event beats a same-cycle clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (winc && wfull)      overflow_d = 1'b1;
    else if (err_clr)       overflow_d = 1'b0;
    if (rinc && rempty)     underflow_d = 1'b1;
    else if (err_clr)       underflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q      <= '0;
      rbin_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      wbin_q      <= '0;
      rbin_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wacc) wbin_q <= wbin_q + PtrOne;
      if (racc) rbin_q <= rbin_q + PtrOne;
      case ({wacc, racc})
        2'b10:   count_q <= count_q + PtrOne;
        2'b01:   count_q <= count_q - PtrOne;
        default: count_q <= count_q;
      endcase
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sfifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .wclk   (clk),
    .wclken (wacc),
    .waddr  (wbin_q[ASIZE-1:0]),
    .wdata  (wdata),
    .raddr  (rbin_q[ASIZE-1:0]),
    .rdata  (mem_rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign rdata = mem_rdata;
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rdata_q <= '0;
      else if (flush) rdata_q <= '0;
      else if (racc)  rdata_q <= mem_rdata;
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Drives an FWFT and a registered-read FIFO with the same stimulus and compares
// both against a queue-based reference model every cycle.
module tb_sync_fifo_ctrl;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned ASIZE = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFULL = 3;
  localparam int unsigned AEMPT = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             winc = 1'b0;
  logic             rinc = 1'b0;
  logic             err_clr = 1'b0;
  logic [DSIZE-1:0] wdata = '0;

  logic             f_wfull, f_wafull, f_rempty, f_raempty, f_ovf, f_udf;
  logic             r_wfull, r_wafull, r_rempty, r_raempty, r_ovf, r_udf;
  logic [DSIZE-1:0] f_rdata, r_rdata;
  logic [ASIZE:0]   f_count, r_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [DSIZE-1:0] m_q[$];
  logic [DSIZE-1:0] m_rreg;
  logic             m_ovf, m_udf;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .DSIZE (DSIZE), .ASIZE (ASIZE), .AFULL_TH (AFULL), .AEMPTY_TH (AEMPT), .FWFT (1)
  ) u_dut_fwft (
    .clk (clk), .rst_n (rst_n), .flush (flush), .wdata (wdata), .winc (winc),
    .wfull (f_wfull), .walmost_full (f_wafull), .rinc (rinc), .rdata (f_rdata),
    .rempty (f_rempty), .ralmost_empty (f_raempty), .count (f_count),
    .overflow (f_ovf), .underflow (f_udf), .err_clr (err_clr)
  );

  sync_fifo_ctrl #(
    .DSIZE (DSIZE), .ASIZE (ASIZE), .AFULL_TH (AFULL), .AEMPTY_TH (AEMPT), .FWFT (0)
  ) u_dut_reg (
    .clk (clk), .rst_n (rst_n), .flush (flush), .wdata (wdata), .winc (winc),
    .wfull (r_wfull), .walmost_full (r_wafull), .rinc (rinc), .rdata (r_rdata),
    .rempty (r_rempty), .ralmost_empty (r_raempty), .count (r_count),
    .overflow (r_ovf), .underflow (r_udf), .err_clr (err_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_rreg = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endfunction

  // Applies one clock edge's worth of FIFO rules to the model.
  function automatic void model_edge();
    bit full, empty;
    if (!rst_n) return;
    if (flush) begin
      model_reset();
      return;
    end
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    if (winc && full) m_ovf = 1'b1;
    else if (err_clr) m_ovf = 1'b0;
    if (rinc && empty) m_udf = 1'b1;
    else if (err_clr)  m_udf = 1'b0;
    if (rinc && !empty) m_rreg = m_q.pop_front();
    if (winc && !full)  m_q.push_back(wdata);
  endfunction

  task automatic check_all();
    int unsigned n;
    n = m_q.size();
    check_eq("f_count",   32'(f_count),   n);
    check_eq("f_wfull",   32'(f_wfull),   32'(n == DEPTH));
    check_eq("f_wafull",  32'(f_wafull),  32'(n >= AFULL));
    check_eq("f_rempty",  32'(f_rempty),  32'(n == 0));
    check_eq("f_raempty", 32'(f_raempty), 32'(n <= AEMPT));
    check_eq("f_ovf",     32'(f_ovf),     32'(m_ovf));
    check_eq("f_udf",     32'(f_udf),     32'(m_udf));
    if (n != 0) check_eq("f_rdata", 32'(f_rdata), 32'(m_q[0]));
    check_eq("r_count",   32'(r_count),   n);
    check_eq("r_wfull",   32'(r_wfull),   32'(n == DEPTH));
    check_eq("r_wafull",  32'(r_wafull),  32'(n >= AFULL));
    check_eq("r_rempty",  32'(r_rempty),  32'(n == 0));
    check_eq("r_raempty", 32'(r_raempty), 32'(n <= AEMPT));
    check_eq("r_ovf",     32'(r_ovf),     32'(m_ovf));
    check_eq("r_udf",     32'(r_udf),     32'(m_udf));
    check_eq("r_rdata",   32'(r_rdata),   32'(m_rreg));
  endtask

  task automatic drive(input bit w, input logic [DSIZE-1:0] d, input bit r,
                       input bit fl, input bit ec);
    winc = w; wdata = d; rinc = r; flush = fl; err_clr = ec;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #3;
    check_all();
    #10 rst_n = 1'b1;
    drive(0, 8'h00, 0, 0, 0);
    repeat (2) cycle();

    // Fill to full, then overflow attempt, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'(8'hA1 + i), 0, 0, 0);
      cycle();
    end
    drive(1, 8'h55, 1, 0, 0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      cycle();
    end

    // Underflow on empty, then clear.
    drive(0, 8'h00, 1, 0, 0);
    cycle();
    drive(0, 8'h00, 0, 0, 1);
    cycle();

    // Hold count at 2 with simultaneous traffic across pointer wrap.
    drive(1, 8'h30, 0, 0, 0); cycle();
    drive(1, 8'h31, 0, 0, 0); cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'(8'h40 + i), 1, 0, 0);
      cycle();
    end

    // count=3 with overflow set, then flush with a write pending.
    drive(1, 8'h60, 0, 0, 0); cycle();
    drive(1, 8'h61, 0, 0, 0); cycle();
    drive(1, 8'h62, 0, 0, 0); cycle();
    drive(0, 8'h00, 1, 0, 0); cycle();
    drive(1, 8'h77, 0, 0, 1); cycle();
    drive(1, 8'h88, 0, 1, 0); cycle();
    drive(0, 8'h00, 0, 0, 0); cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
      cycle();
    end

    // Asynchronous reset mid-burst, checked before any clock edge.
    drive(1, 8'h99, 0, 0, 0); cycle();
    drive(1, 8'h9A, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    cycle();
    rst_n = 1'b1;
    drive(0, 8'h00, 0, 0, 0);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
